// File: rtl/btn_debounce.sv
// Purpose: per-button synchroniser, debouncer and press/release/long-press pulse generator.
// Latency: level/press/release DB_CYCLES+2 cycles after a clean raw edge; long LONG_CYCLES after press.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module btn_debounce #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int N_BTN       = 2,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  // DB_CYCLES must be at least 2 and LONG_CYCLES at least 1 for the counters to be meaningful.
  localparam int DB_CYCLES   = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYCLES = CLOCK_FREQ / 1000 * LONG_MS;
  localparam int DW          = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LW          = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic          r_s0;
    logic          r_s1;
    logic          r_stb;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [DW-1:0] r_dcnt;
    logic [LW-1:0] r_lcnt;
    logic          w_diff;
    logic          w_flip;
    logic          w_lsat;

    // Synchronised value disagrees with the stable level.
    assign w_diff = r_s1 ^ r_stb;
    // Disagreement has persisted for the whole window: stable level flips this edge.
    assign w_flip = w_diff && (r_dcnt == DW'(DB_CYCLES - 1));
    // Long-press counter has hit its ceiling and must hold.
    assign w_lsat = (r_lcnt == LW'(LONG_CYCLES));

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s0 <= 1'b0;
        r_s1 <= 1'b0;
      end else begin
        r_s0 <= btn_raw[gi];
        r_s1 <= r_s0;
      end
    end

    // Stability counter: any return to the stable value restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stb  <= 1'b0;
        r_dcnt <= '0;
      end else if (!w_diff) begin
        r_dcnt <= '0;
      end else if (w_flip) begin
        r_stb  <= r_s1;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end

    // Press/release pulses register alongside the stable-level update, so they align with btn_level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_flip && r_s1;
        r_release <= w_flip && !r_s1;
      end
    end

    // Hold-time counter saturates so the long pulse fires once per hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lcnt <= '0;
        r_long <= 1'b0;
      end else begin
        if (!r_stb) begin
          r_lcnt <= '0;
        end else if (!w_lsat) begin
          r_lcnt <= r_lcnt + LW'(1);
        end
        r_long <= r_stb && (r_lcnt == LW'(LONG_CYCLES - 1));
      end
    end

    assign btn_level[gi]   = r_stb;
    assign btn_press[gi]   = r_press;
    assign btn_release[gi] = r_release;
    assign btn_long[gi]    = r_long;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Purpose: directed scoreboard bench for btn_debounce (DB_CYCLES=4, LONG_CYCLES=10).
// Latency: expected pulse cycles are hand-computed relative to the drive edge.
// Backpressure: none; a monitor pops one expected event whenever any pulse is seen.
`timescale 1ns/1ps
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] lvl;
  } ev_t;

  ev_t exp_q[$];

  btn_debounce #(
    .CLOCK_FREQ (1000),
    .N_BTN      (2),
    .DEBOUNCE_MS(4),
    .LONG_MS    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N (and through the following negedge) cyc reads N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void push(input int c, input logic [1:0] p, input logic [1:0] r,
                               input logic [1:0] l, input logic [1:0] v);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.lvl = v;
    exp_q.push_back(e);
  endfunction

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: any pulse is an output event; compare against the next expected one.
  initial begin
    ev_t    e;
    longint act;
    longint exp;
    forever begin
      @(negedge clk);
      if (rst_n && ((btn_press | btn_release | btn_long) != 2'b00)) begin
        chk($sformatf("press_release_exclusive@%0d", cyc), longint'(btn_press & btn_release), 0);
        act = (longint'(cyc) << 8) | longint'({btn_press, btn_release, btn_long, btn_level});
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_event@%0d {cyc,press,rel,long,lvl}", cyc), act, 0);
        end else begin
          e   = exp_q.pop_front();
          exp = (longint'(e.cyc) << 8) | longint'({e.press, e.rel, e.lng, e.lvl});
          chk($sformatf("event@%0d {cyc,press,rel,long,lvl}", cyc), act, exp);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int   e;
    logic [1:0] seen;

    // Power-on reset: outputs must be zero while held.
    adv(2);
    chk("por_outputs", longint'({btn_level, btn_press, btn_release, btn_long}), 0);
    rst_n = 1'b1;
    adv(3);

    // Clean press/release on channel 1, held long enough to also fire long.
    btn_raw = 2'b10; e = cyc;
    push(e + 6,  2'b10, 2'b00, 2'b00, 2'b10);
    push(e + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    adv(20);
    btn_raw = 2'b00;
    push(e + 26, 2'b00, 2'b10, 2'b00, 2'b00);
    adv(16);

    // Bounce 1,0,1,0,1 on channel 0: press only 6 cycles after the final rise.
    btn_raw = 2'b01; e = cyc;
    adv(1); btn_raw = 2'b00;
    adv(1); btn_raw = 2'b01;
    adv(1); btn_raw = 2'b00;
    adv(1); btn_raw = 2'b01;
    push(e + 10, 2'b01, 2'b00, 2'b00, 2'b01);
    adv(8);
    btn_raw = 2'b00;
    push(e + 18, 2'b00, 2'b01, 2'b00, 2'b00);
    adv(14);

    // Lone 3-cycle glitch on channel 1: no output activity at all.
    btn_raw = 2'b10;
    adv(3);
    btn_raw = 2'b00;
    seen = 2'b00;
    repeat (12) begin
      @(negedge clk);
      seen = seen | btn_level | btn_press | btn_release | btn_long;
    end
    chk("glitch_no_activity", longint'(seen), 0);
    adv(1);

    // Long press on channel 0 held 40 cycles: one long pulse 10 after press.
    btn_raw = 2'b01; e = cyc;
    push(e + 6,  2'b01, 2'b00, 2'b00, 2'b01);
    push(e + 16, 2'b00, 2'b00, 2'b01, 2'b01);
    adv(40);
    btn_raw = 2'b00;
    push(e + 46, 2'b00, 2'b01, 2'b00, 2'b00);
    adv(16);

    // Eight debounced cycles high: no long pulse.
    btn_raw = 2'b01; e = cyc;
    push(e + 6,  2'b01, 2'b00, 2'b00, 2'b01);
    adv(8);
    btn_raw = 2'b00;
    push(e + 14, 2'b00, 2'b01, 2'b00, 2'b00);
    adv(16);

    // Both channels together, releases staggered by 3 cycles.
    btn_raw = 2'b11; e = cyc;
    push(e + 6,  2'b11, 2'b00, 2'b00, 2'b11);
    push(e + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    adv(20);
    btn_raw = 2'b10;
    push(e + 26, 2'b00, 2'b01, 2'b00, 2'b10);
    adv(3);
    btn_raw = 2'b00;
    push(e + 29, 2'b00, 2'b10, 2'b00, 2'b00);
    adv(16);

    // Asynchronous mid-cycle reset with both buttons held.
    btn_raw = 2'b11; e = cyc;
    push(e + 6,  2'b11, 2'b00, 2'b00, 2'b11);
    push(e + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    adv(20);
    chk("level_before_reset", longint'(btn_level), 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level",   longint'(btn_level),   0);
    chk("async_rst_press",   longint'(btn_press),   0);
    chk("async_rst_release", longint'(btn_release), 0);
    chk("async_rst_long",    longint'(btn_long),    0);
    repeat (3) begin
      @(negedge clk);
      chk("held_rst_outputs", longint'({btn_level, btn_press, btn_release, btn_long}), 0);
    end
    adv(1);
    rst_n = 1'b1; e = cyc;
    push(e + 6,  2'b11, 2'b00, 2'b00, 2'b11);
    push(e + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    adv(20);
    btn_raw = 2'b00;
    push(e + 26, 2'b00, 2'b11, 2'b00, 2'b00);
    adv(16);

    // Two-cycle reset pulse while channel 1 is held: treated as a fresh press.
    btn_raw = 2'b10; e = cyc;
    push(e + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    adv(10);
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1; e = cyc;
    push(e + 6,  2'b10, 2'b00, 2'b00, 2'b10);
    push(e + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    adv(20);
    btn_raw = 2'b00;
    push(e + 26, 2'b00, 2'b10, 2'b00, 2'b00);
    adv(16);

    // Every expected event must have been seen.
    chk("events_outstanding", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
